packet_rx_framer: RTL and testbench

- Receive stage directly downstream of the packet transmitter; consumes its byte stream on rx_en/rx_data.
- Frame format: HDR[15:8], HDR[7:0], LEN, LEN payload bytes, TRL[15:8], TRL[7:0].
- Validates framing, buffers payload in an internal FIFO and releases a packet to the consumer only after its trailer checks good. Bad packets are rolled back and counted.

---
 rtl/packet_rx_framer.sv | 91 +++++++++
 tb/tb_packet_rx_framer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/packet_rx_framer.sv
// packet_rx_framer: validates HDR/LEN/payload/TRL frames, buffers payload, releases only committed packets
// Ports: clk, rst_n (async active-low); rx_en/rx_data byte stream in;
// out_valid/out_data/out_last/out_ready committed payload out;
// pkt_ok/pkt_err one-cycle commit/drop pulses; ok_cnt/err_cnt wrapping packet counters.
module packet_rx_framer #(
  parameter int          DEPTH   = 32,
  parameter int          MAX_LEN = 16,
  parameter logic [15:0] HDR     = 16'hDEAD,
  parameter logic [15:0] TRL     = 16'hBEEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [8:0] MAXL = 9'(MAX_LEN);
  localparam logic [2:0] IDLE = 3'd0, HDR2 = 3'd1, LEN = 3'd2, PAYLOAD = 3'd3,
                         TRL1 = 3'd4, TRL2 = 3'd5, DROP = 3'd6;
  logic [2:0]  state, nstate;
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, used;
  logic [7:0]  rem;
  logic [8:0]  free;
  logic [8:0]  mem [DEPTH];
  logic [8:0]  rd_e;
  logic        err, commit, wr, rd, len_bad;
  assign used      = wr_ptr - rd_ptr;
  assign free      = 9'(DEPTH) - 9'(used);
  assign out_valid = rd_ptr != commit_ptr;
  assign rd_e      = mem[rd_ptr[AW-1:0]];
  assign out_data  = out_valid ? rd_e[7:0] : 8'h00;
  assign out_last  = out_valid & rd_e[8];
  assign rd        = out_valid & out_ready;
  assign len_bad   = rx_data == 8'd0 || {1'b0, rx_data} > MAXL || {1'b0, rx_data} > free;
  always_comb begin
    nstate = state;
    err    = 1'b0;
    commit = 1'b0;
    wr     = 1'b0;
    if (!rx_en) begin
      nstate = IDLE;
      err    = state != IDLE && state != DROP;
    end else begin
      case (state)
        IDLE:    begin err = rx_data != HDR[15:8]; nstate = err ? DROP : HDR2; end
        HDR2:    begin err = rx_data != HDR[7:0];  nstate = err ? DROP : LEN;  end
        LEN:     begin err = len_bad;              nstate = err ? DROP : PAYLOAD; end
        PAYLOAD: begin wr = 1'b1; nstate = rem == 8'd1 ? TRL1 : PAYLOAD; end
        TRL1:    begin err = rx_data != TRL[15:8]; nstate = err ? DROP : TRL2; end
        TRL2:    begin err = rx_data != TRL[7:0];  commit = !err; nstate = err ? DROP : IDLE; end
        default: nstate = DROP;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      rem        <= '0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      ok_cnt     <= '0;
      err_cnt    <= '0;
    end else begin
      state   <= nstate;
      pkt_ok  <= commit;
      pkt_err <= err;
      if (err) wr_ptr <= commit_ptr;
      else if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (commit) commit_ptr <= wr_ptr;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (state == LEN && rx_en) rem <= rx_data;
      else if (wr) rem <= rem - 8'd1;
      if (commit) ok_cnt <= ok_cnt + 8'd1;
      if (err) err_cnt <= err_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= {rem == 8'd1, rx_data};
  end
endmodule

// File: tb/tb_packet_rx_framer.sv
// tb_packet_rx_framer: directed self-checking bench for packet_rx_framer
module tb_packet_rx_framer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_en = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, pkt_ok, pkt_err;
  logic [7:0] out_data, ok_cnt, err_cnt;
  int checks = 0;
  int errors = 0;
  int exp_ok = 0;
  int exp_err = 0;
  packet_rx_framer dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_en = 1'b1;
    rx_data = b;
    tick();
  endtask
  task automatic gap();
    rx_en = 1'b0;
    tick();
  endtask
  task automatic hdr(input logic [7:0] len);
    send(8'hDE);
    send(8'hAD);
    send(len);
  endtask
  task automatic trl();
    send(8'hBE);
    send(8'hEF);
  endtask
  task automatic status(input string tag, input logic ok, input logic er);
    chk({tag, "_pkt_ok"}, 32'(pkt_ok), 32'(ok));
    chk({tag, "_pkt_err"}, 32'(pkt_err), 32'(er));
    chk({tag, "_ok_cnt"}, 32'(ok_cnt), 32'(exp_ok));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
  endtask
  task automatic pop(input string tag, input logic [7:0] d, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    rx_en = 1'b0;
    tick();
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    status("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    hdr(8'd5);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h50);
    trl();
    exp_ok = 1;
    status("good1", 1'b1, 1'b0);
    pop("g1b0", 8'h10, 1'b0);
    chk("g1_pulse_once", 32'(pkt_ok), 32'd0);
    pop("g1b1", 8'h20, 1'b0);
    pop("g1b2", 8'h30, 1'b0);
    pop("g1b3", 8'h40, 1'b0);
    pop("g1b4", 8'h50, 1'b1);
    chk("g1_empty", 32'(out_valid), 32'd0);
    hdr(8'd3);
    send(8'h01); send(8'h02); send(8'h03);
    send(8'hBE); send(8'hEE);
    exp_err = 1;
    status("badtrl", 1'b0, 1'b1);
    chk("badtrl_novalid", 32'(out_valid), 32'd0);
    gap();
    chk("badtrl_pulse_once", 32'(pkt_err), 32'd0);
    hdr(8'd2);
    send(8'hAA); send(8'hBB);
    trl();
    exp_ok = 2;
    status("good2", 1'b1, 1'b0);
    pop("g2b0", 8'hAA, 1'b0);
    pop("g2b1", 8'hBB, 1'b1);
    chk("g2_empty", 32'(out_valid), 32'd0);
    hdr(8'd5);
    send(8'h11); send(8'h22);
    gap();
    exp_err = 2;
    status("abort", 1'b0, 1'b1);
    chk("abort_novalid", 32'(out_valid), 32'd0);
    hdr(8'd1);
    send(8'h77);
    trl();
    exp_ok = 3;
    status("good3", 1'b1, 1'b0);
    pop("g3b0", 8'h77, 1'b1);
    chk("g3_empty", 32'(out_valid), 32'd0);
    hdr(8'd0);
    exp_err = 3;
    status("len0", 1'b0, 1'b1);
    trl();
    status("len0_ignored", 1'b0, 1'b0);
    gap();
    hdr(8'd17);
    exp_err = 4;
    status("len17", 1'b0, 1'b1);
    send(8'h01);
    trl();
    status("len17_ignored", 1'b0, 1'b0);
    gap();
    send(8'h55);
    exp_err = 5;
    status("badhdr", 1'b0, 1'b1);
    send(8'hAD); send(8'h01); send(8'h99);
    trl();
    status("badhdr_ignored", 1'b0, 1'b0);
    chk("badhdr_novalid", 32'(out_valid), 32'd0);
    gap();
    out_ready = 1'b0;
    hdr(8'd16);
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
    trl();
    exp_ok = 4;
    status("full_a", 1'b1, 1'b0);
    gap();
    hdr(8'd16);
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    trl();
    exp_ok = 5;
    status("full_b", 1'b1, 1'b0);
    gap();
    hdr(8'd1);
    exp_err = 6;
    status("overflow", 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++)
      pop("drain", i < 16 ? 8'(8'h40 + i) : 8'(8'h80 + i - 16), i == 15 || i == 31);
    chk("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    hdr(8'd2);
    send(8'hC1); send(8'hC2);
    trl();
    exp_ok = 6;
    status("pending", 1'b1, 1'b0);
    gap();
    hdr(8'd3);
    send(8'h01);
    chk("pending_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_ok = 0;
    exp_err = 0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    status("mid_rst", 1'b0, 1'b0);
    rx_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    status("post_rst", 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
